bram_port_arbiter: RTL and testbench
====================================

Name: bram_port_arbiter

Overview:
- Shares the single-port image BRAM (blk_mem_gen instance) among N requesters, e.g. frame loader (write), mode1 VGA readout and mode2 sobel fetch.
- Sits between the requesters and the BRAM port.
- Grants one owner at a time, round-robin, with a bounded burst, and routes read data back tagged to the owner that issued the read.

Parameters:
- N_REQ, 3, number of requesters (2..4).
- AW, 19, BRAM address width.
- DW, 8, data width.
- RD_LAT, 2, BRAM read latency in cycles (1..3).
- MAX_BURST, 64, maximum beats per grant before forced re-arbitration.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-high reset.
- req_i  input  N_REQ  per-requester access request, level.
- we_i  input  N_REQ  per-requester write strobe, qualifies the beat.
- addr_i  input  N_REQ*AW  packed addresses; requester k uses bits [k*AW +: AW].
- wdata_i  input  N_REQ*DW  packed write data.
- gnt_o  output  N_REQ  one-hot registered grant.
- rvalid_o  output  N_REQ  one-hot read-data valid.
- rdata_o  output  DW  read data; valid only with rvalid_o.
- ena_o  output  1  BRAM enable.
- wea_o  output  1  BRAM write enable.
- addr_o  output  AW  BRAM address.
- d2mem_o  output  DW  BRAM write data.
- mem2d_i  input  DW  BRAM read data.
- busy_o  output  1  a grant is held or reads are in flight.

Behaviour:
- Reset: one clock (clk); reset is asynchronous and active-high on rst. While rst is high, all outputs are 0, state=IDLE, round-robin pointer=0, burst count=0, and the read tag pipeline is flushed.
- Beat definition: a beat is accepted in a cycle when req_i[k] & gnt_o[k].
  - BRAM signals are combinational from the owner's inputs in that cycle: ena_o=1, wea_o=we_i[k], addr_o/d2mem_o = owner's slice.
  - With no accepted beat: ena_o=0, wea_o=0, addr_o and d2mem_o are 0.
- FSM states: IDLE, GRANT.
  - IDLE: if any req_i bit is set, pick the first requesting index starting at pointer+1 (mod N_REQ). Register it into gnt_o and go to GRANT. Winner's first beat is accepted the cycle after its req rises (1-cycle grant latency).
  - GRANT, owner k: burst count increments on each accepted beat.
  - Release (GRANT -> IDLE, gnt_o cleared next cycle, pointer=k) when either:
    - req_i[k]=0, or
    - the accepted beat takes the count to MAX_BURST; that beat is still performed.
  - Burst count clears on release. One idle bubble cycle always separates successive owners.
- Simultaneous requests in IDLE: round-robin order only. A requester never waits more than (N_REQ-1) bursts.
- Read return: each accepted beat with we=0 pushes tag k into an RD_LAT-deep shift register.
  - RD_LAT cycles later: rvalid_o[k]=1, rdata_o=mem2d_i (passed through, not re-registered).
  - Writes push an empty tag.
  - Returns continue after grant release and across owner changes; ordering is preserved.
- busy_o = (state==GRANT) | any tag in flight.
- Requests to a requester whose req drops mid-burst: no further beats; in-flight reads still return.
- rst asserted mid-burst: grant and in-flight reads are dropped, no rvalid pulses after reset release.

Optional Feature:
- ARB_FIXED_PRIO_EN
  - Defined: IDLE picks the lowest requesting index regardless of pointer, and MAX_BURST is still enforced. Index 0 (loader) is intended highest.
  - Undefined: round-robin as specified above.

Test Plan:
- Reset/idle: rst=1 for 3 cycles with req_i=3'b111 -> gnt_o=0, ena_o=0, rvalid_o=0. After release, gnt_o=3'b010 (pointer 0 -> index 1 first) one cycle later.
- Single read burst: requester 2 reads addr 100..103, RD_LAT=2 -> ena_o on 4 consecutive cycles. rvalid_o[2] on 4 cycles starting 2 cycles after the first beat, rdata_o = BRAM model contents in order.
- Burst limit: MAX_BURST=4, req_i[0] held high with req_i[1] high -> exactly 4 beats by 0, one bubble, then gnt_o=3'b010.
- Fairness: all three req held, MAX_BURST=2 -> grant order 1,2,0,1,2,0. No requester starved for more than 2 bursts.
- Write then read: requester 0 writes 0xA5 at addr 7, releases, requester 1 reads addr 7 -> rvalid_o[1] with rdata_o=0xA5. No rvalid for the write beat.
- Reset mid-flight: assert rst one cycle after a read beat -> no rvalid_o pulse at any later cycle, busy_o=0 after reset.

Source files
------------

// File: rtl/bram_port_arbiter.sv
// rtl/bram_port_arbiter.sv - round-robin, burst-bounded arbiter sharing one BRAM port among N_REQ requesters.
// Define ARB_FIXED_PRIO_EN to make idle arbitration pick the lowest requesting index instead.
module bram_port_arbiter #(
    parameter int N_REQ     = 3,
    parameter int AW        = 19,
    parameter int DW        = 8,
    parameter int RD_LAT    = 2,
    parameter int MAX_BURST = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req_i,
    input  logic [N_REQ-1:0]    we_i,
    input  logic [N_REQ*AW-1:0] addr_i,
    input  logic [N_REQ*DW-1:0] wdata_i,
    output logic [N_REQ-1:0]    gnt_o,
    output logic [N_REQ-1:0]    rvalid_o,
    output logic [DW-1:0]       rdata_o,
    output logic                ena_o,
    output logic                wea_o,
    output logic [AW-1:0]       addr_o,
    output logic [DW-1:0]       d2mem_o,
    input  logic [DW-1:0]       mem2d_i,
    output logic                busy_o
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t                         state_q, state_d;
    logic [N_REQ-1:0]               gnt_q, gnt_d;
    logic [PW-1:0]                  ptr_q, ptr_d;
    logic [CW-1:0]                  cnt_q, cnt_d;
    logic [RD_LAT-1:0][N_REQ-1:0]   tag_q, tag_d;

    logic [N_REQ-1:0] beat_vec;
    logic             beat;
    logic [PW-1:0]    owner;
    logic [PW-1:0]    pick;
    logic             pick_vld;

    assign beat_vec = req_i & gnt_q;
    assign beat     = |beat_vec;

    always_comb begin
        owner = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (gnt_q[k]) owner = PW'(k);
        end
    end

    // BRAM port is driven straight from the owner's inputs during an accepted beat.
    always_comb begin
        ena_o   = 1'b0;
        wea_o   = 1'b0;
        addr_o  = '0;
        d2mem_o = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (beat_vec[k]) begin
                ena_o   = 1'b1;
                wea_o   = we_i[k];
                addr_o  = addr_i[k*AW +: AW];
                d2mem_o = wdata_i[k*DW +: DW];
            end
        end
    end

    // Loops run from the least to the most preferred index so the last hit wins.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
`ifdef ARB_FIXED_PRIO_EN
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_i[k]) begin
                pick     = PW'(k);
                pick_vld = 1'b1;
            end
        end
`else
        for (int i = N_REQ; i >= 1; i--) begin
            if (req_i[(int'(ptr_q) + i) % N_REQ]) begin
                pick     = PW'((int'(ptr_q) + i) % N_REQ);
                pick_vld = 1'b1;
            end
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    gnt_d   = N_REQ'(1) << pick;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (!beat || (cnt_q == CW'(MAX_BURST - 1))) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    ptr_d   = owner;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // Read tags ride a shift register so each return lands on the requester that issued it.
    always_comb begin
        tag_d    = '0;
        tag_d[0] = (beat && !wea_o) ? beat_vec : '0;
        for (int s = 1; s < RD_LAT; s++) begin
            tag_d[s] = tag_q[s-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            tag_q   <= tag_d;
        end
    end

    assign gnt_o    = gnt_q;
    assign rvalid_o = tag_q[RD_LAT-1];
    assign rdata_o  = (|rvalid_o) ? mem2d_i : '0;
    assign busy_o   = (state_q == GRANT) || (|tag_q);

endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb/tb_bram_port_arbiter.sv - randomized and directed bench for bram_port_arbiter against a transaction-level model.
module tb_bram_port_arbiter;

    localparam int N_REQ     = 3;
    localparam int AW        = 8;
    localparam int DW        = 8;
    localparam int RD_LAT    = 2;
    localparam int MAX_BURST = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic [N_REQ-1:0]    req_i, we_i;
    logic [N_REQ*AW-1:0] addr_i;
    logic [N_REQ*DW-1:0] wdata_i;
    logic [N_REQ-1:0]    gnt_o, rvalid_o;
    logic [DW-1:0]       rdata_o, d2mem_o, mem2d_i;
    logic                ena_o, wea_o, busy_o;
    logic [AW-1:0]       addr_o;

    bram_port_arbiter #(
        .N_REQ(N_REQ), .AW(AW), .DW(DW), .RD_LAT(RD_LAT), .MAX_BURST(MAX_BURST)
    ) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
        .ena_o(ena_o), .wea_o(wea_o), .addr_o(addr_o), .d2mem_o(d2mem_o),
        .mem2d_i(mem2d_i), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    // Behavioural BRAM: read-first, two registered stages of read latency.
    logic [DW-1:0] mem [256];
    logic [DW-1:0] rd_p1, rd_p2;
    always @(posedge clk) begin
        rd_p1 <= mem[addr_o];
        rd_p2 <= rd_p1;
        if (ena_o && wea_o) mem[addr_o] = d2mem_o;
    end
    assign mem2d_i = rd_p2;

    typedef struct {
        int            due;
        int            who;
        logic [DW-1:0] data;
    } ret_t;

    int            n_chk = 0;
    int            n_fail = 0;
    int            cyc = 0;
    int            m_owner = -1;
    int            m_ptr = 0;
    int            m_beats = 0;
    logic [DW-1:0] ref_mem [256];
    ret_t          pend [$];
    int            order [$];
    logic [N_REQ-1:0] prev_gnt = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock cycle: check this cycle's outputs at the falling edge, advance the model, return at posedge+1.
    task automatic step();
        logic [N_REQ-1:0] eg, erv;
        logic             ew, eb;
        logic [DW-1:0]    ea, ed, erd;
        bit               beat;
        @(negedge clk);
        cyc++;
        if (rst) begin
            m_owner = -1; m_ptr = 0; m_beats = 0;
            pend.delete();
        end
        eg   = (m_owner >= 0) ? N_REQ'(1 << m_owner) : '0;
        beat = !rst && (m_owner >= 0) && req_i[m_owner];
        ew   = beat ? we_i[m_owner] : 1'b0;
        ea   = beat ? addr_i[m_owner*AW +: AW] : '0;
        ed   = beat ? wdata_i[m_owner*DW +: DW] : '0;
        erv  = '0;
        erd  = '0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            erv = N_REQ'(1 << pend[0].who);
            erd = pend[0].data;
            void'(pend.pop_front());
        end
        eb = (m_owner >= 0) || (pend.size() > 0) || (erv != 0);
        chk("gnt", 32'(gnt_o), 32'(eg));
        chk("ena", 32'(ena_o), 32'(beat));
        chk("wea", 32'(wea_o), 32'(ew));
        chk("addr", 32'(addr_o), 32'(ea));
        chk("d2mem", 32'(d2mem_o), 32'(ed));
        chk("rvalid", 32'(rvalid_o), 32'(erv));
        chk("busy", 32'(busy_o), 32'(eb));
        if (erv != 0) chk("rdata", 32'(rdata_o), 32'(erd));
        if (!rst) begin
            if (beat) begin
                if (ew) ref_mem[ea] = ed;
                else    pend.push_back('{cyc + RD_LAT, m_owner, ref_mem[ea]});
            end
            if (m_owner < 0) begin
`ifdef ARB_FIXED_PRIO_EN
                for (int i = 0; i < N_REQ && m_owner < 0; i++)
                    if (req_i[i]) m_owner = i;
`else
                for (int i = 1; i <= N_REQ && m_owner < 0; i++)
                    if (req_i[(m_ptr + i) % N_REQ]) m_owner = (m_ptr + i) % N_REQ;
`endif
            end else if (!beat) begin
                m_ptr = m_owner; m_owner = -1; m_beats = 0;
            end else begin
                m_beats++;
                if (m_beats == MAX_BURST) begin
                    m_ptr = m_owner; m_owner = -1; m_beats = 0;
                end
            end
        end
        if (gnt_o != 0 && prev_gnt == 0)
            for (int k = 0; k < N_REQ; k++) if (gnt_o[k]) order.push_back(k);
        prev_gnt = gnt_o;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Runs nb beats for requester k at consecutive addresses starting at a, then drops its request.
    task automatic do_burst(input int k, input bit w, input int a, input int d, input int nb);
        int n = 0;
        req_i[k] = 1'b1;
        we_i[k]  = w;
        addr_i[k*AW +: AW]  = AW'(a);
        wdata_i[k*DW +: DW] = DW'(d);
        for (int t = 0; t < 40 && n < nb; t++) begin
            step();
            if (gnt_o[k]) begin
                addr_i[k*AW +: AW] = AW'(a + n);
                n++;
            end
        end
        chk("burst_beats", 32'(n), 32'(nb));
        step();
        req_i[k] = 1'b0;
    endtask

    initial begin
        int exp_ord [6];
        int got, rv_cnt;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = DW'($urandom);
            ref_mem[i] = mem[i];
        end
        rst = 1'b1; req_i = '1; we_i = '0; addr_i = '0; wdata_i = '0;
        idle_steps(3);
        rst = 1'b0;
        step();
`ifdef ARB_FIXED_PRIO_EN
        chk("first_grant", 32'(gnt_o), 32'b001);
`else
        chk("first_grant", 32'(gnt_o), 32'b010);
`endif
        req_i = '0;
        idle_steps(8);

        do_burst(2, 1'b0, 100, 0, 4);
        idle_steps(6);

        do_burst(0, 1'b1, 7, 8'hA5, 1);
        idle_steps(3);
        do_burst(1, 1'b0, 7, 0, 1);
        got = 0;
        for (int i = 0; i < 6; i++) begin
            if (rvalid_o[1]) begin
                got = 1;
                chk("wr_rd_data", 32'(rdata_o), 32'hA5);
            end
            step();
        end
        chk("wr_rd_seen", 32'(got), 32'd1);

        rst = 1'b1; step(); rst = 1'b0;
        order.delete();
        req_i = '1; we_i = '0;
        idle_steps(32);
        req_i = '0;
        idle_steps(8);
`ifdef ARB_FIXED_PRIO_EN
        exp_ord = '{0, 0, 0, 0, 0, 0};
`else
        exp_ord = '{1, 2, 0, 1, 2, 0};
`endif
        chk("fair_count", 32'(order.size() >= 6), 32'd1);
        for (int i = 0; i < 6 && i < order.size(); i++)
            chk("fair_order", 32'(order[i]), 32'(exp_ord[i]));

        req_i[2] = 1'b1; we_i[2] = 1'b0;
        for (int t = 0; t < 10 && !gnt_o[2]; t++) step();
        chk("midrst_grant", 32'(gnt_o[2]), 32'd1);
        step();
        rst = 1'b1; req_i = '0;
        idle_steps(2);
        rst = 1'b0;
        rv_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (rvalid_o != 0) rv_cnt++;
            step();
        end
        chk("midrst_no_rvalid", 32'(rv_cnt), 32'd0);
        chk("midrst_busy", 32'(busy_o), 32'd0);

        for (int i = 0; i < 2000; i++) begin
            for (int k = 0; k < N_REQ; k++)
                if ($urandom_range(3) == 0) req_i[k] = ~req_i[k];
            we_i    = N_REQ'($urandom);
            addr_i  = (N_REQ*AW)'($urandom);
            wdata_i = (N_REQ*DW)'($urandom);
            rst     = ($urandom_range(299) == 0);
            step();
        end
        rst = 1'b0; req_i = '0;
        idle_steps(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
